fifo_wr_arbiter: RTL

Round-robin write arbiter that shares the single write port of the synchronous FIFO between `NUM_REQ` independent producers. Each producer offers bursts over a valid/ready/last interface. The arbiter grants one producer at a time, holds the grant until the burst ends or a fairness limit is hit, and drives the FIFO `wr`/`din` pins. It honours FIFO `full` back-pressure, so no write is ever issued into a full FIFO.

---
 rtl/fifo_wr_arbiter_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_if.sv | 23 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter (package fifo_arb_pkg).
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_CNT_W   = 8;
    localparam int STATS_CNT_W = 16;

    // Index width for n producers, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side valid/ready/last bundle plus the FIFO write pins shared by the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          wr;
    logic [DATA_WIDTH-1:0]         din;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, wr, din
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, wr, din
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    int best_rank;
    int rank;

    // Rank is the distance from ptr in search order; smallest rank wins.
    always_comb begin
        best_rank = NUM_REQ;
        rank      = 0;
        idx       = '0;
        gnt       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rank = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NUM_REQ - int'(ptr));
            if (req[i] && (rank < best_rank)) begin
                best_rank = rank;
                idx       = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = (|req) && (idx == ID_W'(i));
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ bursting producers.
// Optional per-producer grant counters: define FIFO_WR_ARBITER_STATS_EN.
//   state | meaning
//   IDLE  | no owner; pick next producer in round-robin order
//   GRANT | owner streams beats until last or MAX_BURST beats
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 16,
    localparam int ID_W       = id_width(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    fifo_wr_arbiter_if.slave             bus,
    output logic                         busy,
`ifdef FIFO_WR_ARBITER_STATS_EN
    output logic [NUM_REQ*STATS_CNT_W-1:0] grant_cnt,
`endif
    output logic [ID_W-1:0]              grant_id
);

    arb_state_e            state;
    logic [ID_W-1:0]       ptr;
    logic [ARB_CNT_W-1:0]  beat_cnt;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic [ID_W-1:0]       pick_idx;
    logic                  pick_any;

    logic                  in_grant;
    logic                  own_valid;
    logic                  own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  beat;
    logic                  burst_end;
    logic [ID_W-1:0]       next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign pick_any = |pick_gnt;
    assign in_grant = (state == GRANT);

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                own_valid = bus.req_valid[i];
                own_last  = bus.req_last[i];
                own_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // fifo_full gates the write in the same cycle, so a full FIFO never sees wr.
    always_comb begin
        beat          = in_grant & own_valid & ~bus.fifo_full;
        bus.wr        = beat;
        bus.din       = in_grant ? own_data : '0;
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = in_grant & ~bus.fifo_full & (grant_id == ID_W'(i));
        end
    end

    // A forced release at MAX_BURST and a real last on the same beat are one exit.
    assign burst_end = beat & (own_last | (beat_cnt == ARB_CNT_W'(MAX_BURST - 1)));
    assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state    <= GRANT;
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    if (burst_end) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        ptr      <= next_ptr;
                        beat_cnt <= '0;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + ARB_CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt <= '0;
        end else if ((state == IDLE) && pick_any) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pick_gnt[i] && (grant_cnt[i*STATS_CNT_W +: STATS_CNT_W] != {STATS_CNT_W{1'b1}})) begin
                    grant_cnt[i*STATS_CNT_W +: STATS_CNT_W] <=
                        grant_cnt[i*STATS_CNT_W +: STATS_CNT_W] + STATS_CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule
